// File: rtl/arm_spi_loader_if.sv
// Signal bundle between the SPI boot loader and its surroundings.
// The loader side holds the SPI slave port and the RAM write port.
// The environment side holds the ARM SPI master and the RAM.
interface arm_spi_loader_if #(
  parameter int ADDR_W = 18
);
  logic              SCK;
  logic              SSEL;
  logic              MOSI;
  logic              MISO;
  logic              booting;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              overrun;

  // Loader side: receives SPI, issues RAM writes.
  modport master (
    input  SCK, SSEL, MOSI, wr_ready,
    output MISO, booting, wr_valid, wr_addr, wr_data, overrun
  );

  // Environment side: drives SPI, accepts RAM writes.
  modport slave (
    output SCK, SSEL, MOSI, wr_ready,
    input  MISO, booting, wr_valid, wr_addr, wr_data, overrun
  );
endinterface

// File: rtl/arm_spi_loader.sv
// SPI mode-0 boot loader.
// The ARM streams "A5 a2 a1 a0 d d d ..." to write bytes into RAM from a
// big-endian start address. It sends "5A" to release the system from boot.
// All SPI inputs are resynchronised into clk. Every output is a flop.
module arm_spi_loader #(
  parameter int ADDR_W      = 18,  // must match the interface's ADDR_W, at most 24
  parameter int SYNC_STAGES = 2    // at least 2
) (
  input logic             clk,
  input logic             n_reset,
  arm_spi_loader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR2  = 3'd2,
    ST_ADDR1  = 3'd3,
    ST_ADDR0  = 3'd4,
    ST_DATA   = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ssel_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_ssel_prev;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic [7:0]             r_last_byte;
  logic [6:0]             r_tx;
  logic                   r_miso;
  logic                   r_booting;
  logic                   r_wr_valid;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [7:0]             r_wr_data;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_overrun;

  logic w_sck, w_ssel, w_mosi;
  logic w_sck_rise, w_sck_fall, w_ssel_rise, w_ssel_fall, w_ssel_edge;
  logic w_active, w_bit_rise, w_bit_fall, w_byte_done;
  logic [7:0] w_byte;
  logic w_addr_byte, w_data_byte, w_boot_clear, w_wr_free;

  // Reset asserts at once with n_reset and releases two clk edges later.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Resynchronise the SPI pins. Keep the previous SCK and SSEL for edge detection.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sck_sync  <= '0;
      r_ssel_sync <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_ssel_prev <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.SCK};
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], bus.SSEL};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
      r_ssel_prev <= r_ssel_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_ssel      = r_ssel_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_sck_fall  = ~w_sck & r_sck_prev;
  assign w_ssel_fall = ~w_ssel & r_ssel_prev;
  assign w_ssel_rise = w_ssel & ~r_ssel_prev;
  assign w_ssel_edge = w_ssel_fall | w_ssel_rise;
  // If SCK moves in the same cycle as an SSEL edge, the SSEL edge wins.
  assign w_active    = ~w_ssel & ~w_ssel_edge;
  assign w_bit_rise  = w_active & w_sck_rise;
  assign w_bit_fall  = w_active & w_sck_fall;
  assign w_byte      = {r_shift, w_mosi};
  assign w_byte_done = w_bit_rise & (r_bit_cnt == 3'd7);
  // A new write may be loaded when nothing is pending, or when the pending write leaves this cycle.
  assign w_wr_free   = ~r_wr_valid | bus.wr_ready;

  // Hold the protocol state.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Decode the protocol. The next state and the per-byte actions come from the state and the byte just completed.
  always_comb begin
    w_state_next = r_state;
    w_addr_byte  = 1'b0;
    w_data_byte  = 1'b0;
    w_boot_clear = 1'b0;
    if (w_ssel_rise) begin
      w_state_next = ST_IDLE;
    end else if (w_ssel_fall) begin
      w_state_next = ST_CMD;
    end else if (w_byte_done) begin
      case (r_state)
        ST_CMD: begin
          if ((w_byte == 8'hA5) && r_booting) begin
            w_state_next = ST_ADDR2;
          end else begin
            w_state_next = ST_IGNORE;
            w_boot_clear = (w_byte == 8'h5A);
          end
        end
        ST_ADDR2: begin
          w_addr_byte  = 1'b1;
          w_state_next = ST_ADDR1;
        end
        ST_ADDR1: begin
          w_addr_byte  = 1'b1;
          w_state_next = ST_ADDR0;
        end
        ST_ADDR0: begin
          w_addr_byte  = 1'b1;
          w_state_next = ST_DATA;
        end
        ST_DATA: begin
          w_data_byte  = 1'b1;
          w_state_next = ST_DATA;
        end
        ST_IGNORE: w_state_next = ST_IGNORE;
        ST_IDLE:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Receive MOSI bits. Either SSEL edge drops a partial byte. Remember the last complete byte for MISO.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_last_byte <= 8'h00;
    end else begin
      if (w_ssel_edge) begin
        r_bit_cnt <= 3'd0;
      end else if (w_bit_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte[6:0];
      end
      if (w_byte_done) r_last_byte <= w_byte;
    end
  end

  // Drive MISO on SCK falling edges. Reload the last complete byte at select and at every byte boundary.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx   <= 7'd0;
      r_miso <= 1'b0;
    end else if (w_ssel_fall || (w_bit_fall && (r_bit_cnt == 3'd0))) begin
      r_tx   <= r_last_byte[6:0];
      r_miso <= r_last_byte[7];
    end else if (w_bit_fall) begin
      r_tx   <= {r_tx[5:0], 1'b0};
      r_miso <= r_tx[6];
    end
  end

  // Assemble the start address and advance it per data byte, including dropped bytes.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_addr <= '0;
    end else if (w_addr_byte) begin
      r_addr <= ADDR_W'({r_addr, w_byte});
    end else if (w_data_byte) begin
      r_addr <= r_addr + ADDR_W'(1'b1);
    end
  end

  // RAM write port. A byte completing while a write is still blocked is dropped and flagged.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_overrun  <= 1'b0;
    end else if (w_data_byte && w_wr_free) begin
      r_wr_valid <= 1'b1;
      r_wr_addr  <= r_addr;
      r_wr_data  <= w_byte;
    end else if (w_data_byte) begin
      r_overrun  <= 1'b1;
    end else if (r_wr_valid && bus.wr_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

  // booting is cleared once by the release command and stays cleared until reset.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)          r_booting <= 1'b1;
    else if (w_boot_clear) r_booting <= 1'b0;
  end

  assign bus.MISO     = r_miso;
  assign bus.booting  = r_booting;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.overrun  = r_overrun;

endmodule
